// File: rtl/turing_step_ctrl.sv
// Sequencer for the Turing-machine datapath: fetches a rule per step, drives the
// tape rewrite/shift pulses and tracks machine state and step count.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; registered outputs hold
//   FETCH | read rule at {state, head_sym}, latch it, halt check
//   WRITE | toggle head cell if the rule writes the other symbol
//   MOVE  | shift tape, commit next state and step count, limit check
//   DONE  | run finished (halt or step limit); waiting for start
module turing_step_ctrl #(
    parameter int SW = 3,
    parameter int CW = 16,
    localparam int AW = SW + 1,
    localparam int DW = SW + 3
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] max_steps,
    input  logic          head_sym,
    input  logic [DW-1:0] rule_data,
    output logic          rule_re,
    output logic [AW-1:0] rule_addr,
    output logic          tape_rewrite,
    output logic          tape_en,
    output logic          tape_left,
    output logic [SW-1:0] state,
    output logic [CW-1:0] step_count,
    output logic          busy,
    output logic          halted,
    output logic          timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_MOVE,
        S_DONE
    } fsm_t;

    fsm_t          fsm, fsm_nxt;
    logic [SW-1:0] state_nxt;
    logic [CW-1:0] count_nxt, step_inc, max_q, max_nxt;
    logic          halted_nxt, timeout_nxt;
    // Latched rule without its halt bit: {next_state, write_bit, move_left}
    logic [DW-2:0] rule_q, rule_nxt;
    logic          sym_q, sym_nxt;

    assign step_inc = step_count + 1'b1;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            fsm        <= S_IDLE;
            state      <= '0;
            step_count <= '0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
            rule_q     <= '0;
            sym_q      <= 1'b0;
            max_q      <= '0;
        end else begin
            fsm        <= fsm_nxt;
            state      <= state_nxt;
            step_count <= count_nxt;
            halted     <= halted_nxt;
            timeout    <= timeout_nxt;
            rule_q     <= rule_nxt;
            sym_q      <= sym_nxt;
            max_q      <= max_nxt;
        end
    end

    always_comb begin
        fsm_nxt      = fsm;
        state_nxt    = state;
        count_nxt    = step_count;
        halted_nxt   = halted;
        timeout_nxt  = timeout;
        rule_nxt     = rule_q;
        sym_nxt      = sym_q;
        max_nxt      = max_q;
        rule_re      = 1'b0;
        rule_addr    = '0;
        tape_rewrite = 1'b0;
        tape_en      = 1'b0;
        tape_left    = 1'b0;
        busy         = 1'b0;

        case (fsm)
            S_IDLE, S_DONE: begin
                if (start && !stop) begin
                    fsm_nxt     = S_FETCH;
                    state_nxt   = '0;
                    count_nxt   = '0;
                    halted_nxt  = 1'b0;
                    timeout_nxt = 1'b0;
                end
            end
            S_FETCH: begin
                busy      = 1'b1;
                rule_re   = 1'b1;
                rule_addr = {state, head_sym};
                if (stop) begin
                    fsm_nxt = S_IDLE;
                end else begin
                    rule_nxt = rule_data[DW-1:1];
                    sym_nxt  = head_sym;
                    max_nxt  = max_steps;
                    if (rule_data[0]) begin
                        fsm_nxt    = S_DONE;
                        halted_nxt = 1'b1;
                    end else begin
                        fsm_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                busy         = 1'b1;
                tape_rewrite = rule_q[1] ^ sym_q;
                fsm_nxt      = stop ? S_IDLE : S_MOVE;
            end
            S_MOVE: begin
                busy      = 1'b1;
                tape_en   = 1'b1;
                tape_left = rule_q[0];
                if (stop) begin
                    fsm_nxt = S_IDLE;
                end else begin
                    state_nxt = rule_q[DW-2:2];
                    count_nxt = step_inc;
                    // The limit counts completed steps; 0 disables it and lets the counter wrap
                    if ((max_q != '0) && (step_inc == max_q)) begin
                        fsm_nxt     = S_DONE;
                        timeout_nxt = 1'b1;
                    end else begin
                        fsm_nxt = S_FETCH;
                    end
                end
            end
            default: fsm_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_turing_step_ctrl.sv
// Bench for turing_step_ctrl: a 64-cell circular tape driven by the DUT pulses and a
// trace-level machine model that predicts every busy cycle of a run.
module tb_turing_step_ctrl;
    localparam int SW = 3;
    localparam int CW = 16;
    localparam int AW = SW + 1;
    localparam int DW = SW + 3;

    logic          clock = 1'b0;
    logic          reset_L, start, stop;
    logic [CW-1:0] max_steps;
    logic          head_sym;
    logic [DW-1:0] rule_data;
    logic          rule_re, tape_rewrite, tape_en, tape_left, busy, halted, timeout;
    logic [AW-1:0] rule_addr;
    logic [SW-1:0] state;
    logic [CW-1:0] step_count;

    turing_step_ctrl #(.SW(SW), .CW(CW)) dut (
        .clock(clock), .reset_L(reset_L), .start(start), .stop(stop),
        .max_steps(max_steps), .head_sym(head_sym), .rule_data(rule_data),
        .rule_re(rule_re), .rule_addr(rule_addr), .tape_rewrite(tape_rewrite),
        .tape_en(tape_en), .tape_left(tape_left), .state(state),
        .step_count(step_count), .busy(busy), .halted(halted), .timeout(timeout)
    );

    always #5 clock = ~clock;

    // Environment: rule memory and tape register (bit 0 under the head)
    logic [DW-1:0] rule_mem [0:15];
    logic [63:0]   env_tape, tape_init;
    logic          tape_load;
    assign head_sym  = env_tape[0];
    assign rule_data = rule_mem[rule_addr];

    always @(posedge clock) begin
        if (tape_load)         env_tape <= tape_init;
        else if (tape_rewrite) env_tape[0] <= ~env_tape[0];
        else if (tape_en)      env_tape <= tape_left ? {env_tape[62:0], env_tape[63]}
                                                     : {env_tape[0], env_tape[63:1]};
    end

    // Model: tape as cell array plus head index; a run is a list of expected busy cycles
    typedef struct {
        logic          re;
        logic [AW-1:0] addr;
        logic          rew, en, left;
        logic [SW-1:0] st;
        logic [CW-1:0] cnt;
        logic [63:0]   cells;
        int            head;
    } ent_t;

    ent_t          trace[$];
    logic [63:0]   m_cells;
    int            m_head;
    logic [SW-1:0] m_state, fin_state;
    logic [CW-1:0] m_cnt, fin_cnt;
    logic          m_halted, m_timeout, fin_halted, fin_timeout;
    int            n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] pk(input logic b, input logic re, input logic [AW-1:0] a,
        input logic rw, input logic en, input logic lf, input logic [SW-1:0] st,
        input logic [CW-1:0] cn, input logic h, input logic t);
        return {b, re, a, rw, en, lf, st, cn, h, t};
    endfunction

    function automatic logic [29:0] dut_vec();
        return pk(busy, rule_re, rule_addr, tape_rewrite, tape_en, tape_en & tape_left,
                  state, step_count, halted, timeout);
    endfunction

    function automatic ent_t mk(input logic re, input logic [AW-1:0] a, input logic rw,
        input logic en, input logic lf, input logic [SW-1:0] st, input logic [CW-1:0] cn,
        input logic [63:0] c, input int h);
        ent_t e;
        e.re = re; e.addr = a; e.rew = rw; e.en = en; e.left = lf;
        e.st = st; e.cnt = cn; e.cells = c; e.head = h;
        return e;
    endfunction

    task automatic cmp_ent(input string tag, input ent_t e);
        chk(tag, 64'(dut_vec()), 64'(pk(1'b1, e.re, e.addr, e.rew, e.en, e.en & e.left,
                                        e.st, e.cnt, 1'b0, 1'b0)));
    endtask

    task automatic cmp_idle(input string tag);
        chk(tag, 64'(dut_vec()), 64'(pk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0,
                                        m_state, m_cnt, m_halted, m_timeout)));
    endtask

    task automatic cmp_tape(input string tag);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[i] = m_cells[(m_head + i) % 64];
        chk(tag, env_tape, v);
    endtask

    // Execute the machine from state 0 on the model tape, one entry per busy cycle
    task automatic build(input logic [CW-1:0] mx);
        logic [63:0]   c = m_cells;
        int            h = m_head;
        logic [SW-1:0] s = '0;
        logic [CW-1:0] n = '0;
        logic          sym, rw;
        logic [DW-1:0] r;
        trace.delete();
        fin_halted = 1'b0;
        fin_timeout = 1'b0;
        while (trace.size() < 240) begin
            sym = c[h];
            r = rule_mem[{s, sym}];
            trace.push_back(mk(1'b1, {s, sym}, 1'b0, 1'b0, 1'b0, s, n, c, h));
            if (r[0]) begin
                fin_halted = 1'b1;
                break;
            end
            rw = (r[2] != sym);
            if (rw) c[h] = ~c[h];
            trace.push_back(mk(1'b0, '0, rw, 1'b0, 1'b0, s, n, c, h));
            h = r[1] ? (h + 63) % 64 : (h + 1) % 64;
            trace.push_back(mk(1'b0, '0, 1'b0, 1'b1, r[1], s, n, c, h));
            s = r[5:3];
            n = n + 1'b1;
            if (mx != '0 && n == mx) begin
                fin_timeout = 1'b1;
                break;
            end
        end
        fin_state = s;
        fin_cnt = n;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle
    task automatic run(input logic [CW-1:0] mx, input int stop_at, input int rst_at,
                       input logic rand_start, output int bc);
        build(mx);
        bc = 0;
        max_steps = mx;
        start = 1'b1;
        stop = 1'b0;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < trace.size(); k++) begin
            cmp_ent($sformatf("run_cyc%0d", k), trace[k]);
            bc++;
            if (k == rst_at) begin
                start = 1'b0;
                #1 reset_L = 1'b0;
                #1 chk("async_reset_outputs", 64'(dut_vec()), 64'd0);
                @(negedge clock);
                reset_L = 1'b1;
                if (k > 0) begin
                    m_cells = trace[k-1].cells;
                    m_head = trace[k-1].head;
                end
                m_state = '0; m_cnt = '0; m_halted = 1'b0; m_timeout = 1'b0;
                cmp_idle("after_reset_idle");
                cmp_tape("after_reset_tape");
                return;
            end
            if (k == stop_at) begin
                stop = 1'b1;
                @(negedge clock);
                stop = 1'b0;
                start = 1'b0;
                m_cells = trace[k].cells;
                m_head = trace[k].head;
                m_state = trace[k].st; m_cnt = trace[k].cnt;
                m_halted = 1'b0; m_timeout = 1'b0;
                cmp_idle("after_stop_idle");
                cmp_tape("after_stop_tape");
                return;
            end
            start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clock);
        end
        start = 1'b0;
        if (!(fin_halted || fin_timeout))
            chk("run_unterminated_in_model", 64'd0, 64'd1);
        m_cells = trace[trace.size()-1].cells;
        m_head = trace[trace.size()-1].head;
        m_state = fin_state; m_cnt = fin_cnt;
        m_halted = fin_halted; m_timeout = fin_timeout;
        cmp_idle("done_outputs");
        cmp_tape("done_tape");
    endtask

    task automatic idle(input int n, input logic both);
        start = both;
        stop = both;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            cmp_idle(both ? "start_stop_hold" : "idle_hold");
        end
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic load_tape(input logic [63:0] v);
        tape_init = v;
        tape_load = 1'b1;
        @(negedge clock);
        tape_load = 1'b0;
        m_cells = v;
        m_head = 0;
    endtask

    task automatic fill_rules(input logic [DW-1:0] v);
        for (int i = 0; i < 16; i++) rule_mem[i] = v;
    endtask

    initial begin
        int bc, sa, ra;
        logic [CW-1:0] mx;
        logic [DW-1:0] r;
        reset_L = 1'b0; start = 1'b0; stop = 1'b0; max_steps = '0;
        tape_load = 1'b0; tape_init = '0;
        fill_rules(6'b000001);
        m_state = '0; m_cnt = '0; m_halted = 1'b0; m_timeout = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_outputs", 64'(dut_vec()), 64'd0);
        reset_L = 1'b1;
        load_tape(64'd0);
        cmp_idle("post_reset_idle");

        // Immediate halt
        run(16'd0, -1, -1, 1'b0, bc);
        chk("imm_halt_busy_cycles", bc, 1);
        chk("imm_halt_halted", halted, 1);
        chk("imm_halt_steps", step_count, 0);

        // Single write-and-move: {next 1, write 1, right}
        rule_mem[0] = 6'b001100;
        run(16'd0, -1, -1, 1'b0, bc);
        chk("single_busy_cycles", bc, 4);
        chk("single_state", state, 1);
        chk("single_steps", step_count, 1);
        chk("single_halted", halted, 1);

        // Same-symbol write, move left
        fill_rules(6'b000001);
        rule_mem[1] = 6'b001110;
        load_tape(64'h1);
        run(16'd0, -1, -1, 1'b0, bc);
        chk("same_sym_busy_cycles", bc, 4);
        chk("same_sym_tape", env_tape, 64'h2);

        // Step limit with a self-looping rule
        fill_rules(6'b000000);
        load_tape(64'h0);
        run(16'd5, -1, -1, 1'b0, bc);
        chk("limit_busy_cycles", bc, 15);
        chk("limit_timeout", timeout, 1);
        chk("limit_halted", halted, 0);
        chk("limit_steps", step_count, 5);
        idle(3, 1'b1);

        // Stop in WRITE of step 3, then restart
        run(16'd0, 7, -1, 1'b0, bc);
        chk("stop_steps", step_count, 2);
        chk("stop_busy", busy, 0);
        idle(2, 1'b0);
        run(16'd4, -1, -1, 1'b1, bc);
        chk("restart_steps", step_count, 4);

        // Asynchronous reset during MOVE of step 2, then a normal run
        run(16'd0, -1, 5, 1'b0, bc);
        run(16'd3, -1, -1, 1'b0, bc);
        chk("post_reset_run_steps", step_count, 3);

        // Random machines, tapes, limits, stops and resets
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 16; i++) begin
                r = DW'($urandom);
                r[0] = ($urandom_range(0, 7) == 0);
                rule_mem[i] = r;
            end
            load_tape({$urandom, $urandom});
            mx = ($urandom_range(0, 3) == 0) ? 16'd0 : CW'($urandom_range(1, 12));
            build(mx);
            sa = -1;
            ra = -1;
            if (!(fin_halted || fin_timeout) || $urandom_range(0, 3) == 0)
                sa = $urandom_range(0, trace.size() - 1);
            else if ($urandom_range(0, 7) == 0)
                ra = $urandom_range(0, trace.size() - 1);
            run(mx, sa, ra, 1'b1, bc);
            idle(2, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
